// File: rtl/raw_rgb_pkg.sv
// Shared types and defaults for the RGB-to-raw Bayer mosaic path.
// Holds the CFA phase and colour-select enums plus the colour-select rule.
package raw_rgb_pkg;

  typedef enum logic [1:0] {
    RGGB = 2'd0,
    GRBG = 2'd1,
    GBRG = 2'd2,
    BGGR = 2'd3
  } bayer_phase_t;

  typedef enum logic [1:0] {
    SEL_R,
    SEL_G,
    SEL_B
  } colour_sel_t;

  localparam int unsigned DEFAULT_LINE_PIXELS = 1280;
  localparam int unsigned DEFAULT_FRAME_LINES = 720;

  // Even/even picks red, odd/odd picks blue, mixed parity is a green site.
  function automatic colour_sel_t colour_select(input logic line_par, input logic col_par);
    if (!line_par && !col_par) return SEL_R;
    else if (line_par && col_par) return SEL_B;
    else return SEL_G;
  endfunction

endpackage

// File: rtl/delay_rg.sv
// Fixed-depth register delay line for a W-bit bundle of strobes.
// Every stage is cleared by reset so no stale strobe survives a flush.
module delay_rg #(
  parameter int unsigned W = 1,
  parameter int unsigned D = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [D-1:0][W-1:0] stage;

  // NOTE: this is a short strobe pipeline, not a storage array, so every stage is reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(D); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[D-1];

endmodule

// File: rtl/rgb2raw_bayer_mosaic.sv
// Converts an RGB pixel stream to a single-sample Bayer raw stream,
// tracking line/column position and flagging line-length and sop/valid errors.
module rgb2raw_bayer_mosaic
  import raw_rgb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned LINE_PIXELS = DEFAULT_LINE_PIXELS,
  parameter int unsigned FRAME_LINES = DEFAULT_FRAME_LINES,
  parameter int unsigned BAYER_PHASE = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [DATA_WIDTH-1:0] g_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  rgb_valid,
  input  logic                  rgb_sop,
  input  logic                  rgb_eop,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_valid,
  output logic                  raw_sop,
  output logic                  raw_eop,
  output logic                  frame_done,
  output logic                  err_line_len,
  output logic                  err_protocol
);

  localparam int unsigned COL_W  = $clog2(LINE_PIXELS) + 1;
  localparam int unsigned LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [COL_W-1:0]  COL_MAX   = '1;
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam bayer_phase_t      PHASE     = bayer_phase_t'(BAYER_PHASE[1:0]);
  localparam logic [1:0]        PHASE_BITS = PHASE;

  typedef enum logic {
    S_WAIT_SOP,
    S_IN_LINE
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d, col_cur;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                accept, err_proto, err_len, frame_end;
  colour_sel_t         sel;
  logic [DATA_WIDTH-1:0] sel_data, data_q1;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    line_d    = line_q;
    col_cur   = col_q;
    accept    = 1'b0;
    err_proto = 1'b0;
    err_len   = 1'b0;
    frame_end = 1'b0;
    if (rgb_valid) begin
      if (state_q == S_WAIT_SOP && !rgb_sop) begin
        err_proto = 1'b1;
      end else begin
        accept = 1'b1;
        if (rgb_sop) begin
          col_cur = '0;
          if (state_q == S_IN_LINE) begin
            err_proto = 1'b1;
            err_len   = 1'b1;
          end
        end
        col_d = (col_cur == COL_MAX) ? col_cur : col_cur + 1'b1;
        if (rgb_eop) begin
          state_d = S_WAIT_SOP;
          if ((32'(col_cur) + 32'd1) != LINE_PIXELS) err_len = 1'b1;
          if (line_q == LINE_LAST) begin
            line_d    = '0;
            frame_end = 1'b1;
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          state_d = S_IN_LINE;
        end
      end
    end
  end

  always_comb begin
    sel = colour_select(line_q[0] ^ PHASE_BITS[1], col_cur[0] ^ PHASE_BITS[0]);
    unique case (sel)
      SEL_R:   sel_data = r_data;
      SEL_B:   sel_data = b_data;
      default: sel_data = g_data;
    endcase
  end

  // NOTE: sequential state is always assigned non-blocking so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_WAIT_SOP;
      col_q    <= '0;
      line_q   <= '0;
      data_q1  <= '0;
      raw_data <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      line_q   <= line_d;
      // Only accepted pixels load, so the output holds through gaps.
      if (accept) data_q1 <= sel_data;
      raw_data <= data_q1;
    end
  end

  delay_rg #(.W(3), .D(2)) u_strobe_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({accept, accept & rgb_sop, accept & rgb_eop}),
    .q       ({raw_valid, raw_sop, raw_eop})
  );

  delay_rg #(.W(3), .D(2)) u_flag_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({frame_end, err_len, err_proto}),
    .q       ({frame_done, err_line_len, err_protocol})
  );

endmodule

// File: tb/tb_rgb2raw_bayer_mosaic.sv
// Self-checking bench: RGGB and BGGR instances share one stimulus stream and
// are compared cycle by cycle against a line/column reference model.
module tb_rgb2raw_bayer_mosaic;

  localparam int LP  = 4;
  localparam int FL  = 3;
  localparam int SAT = (1 << ($clog2(LP) + 1)) - 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] r_data = '0, g_data = '0, b_data = '0;
  logic       rgb_valid = 1'b0, rgb_sop = 1'b0, rgb_eop = 1'b0;

  logic [7:0] raw_data_a, raw_data_b;
  logic       raw_valid_a, raw_sop_a, raw_eop_a, frame_done_a, err_line_len_a, err_protocol_a;
  logic       raw_valid_b, raw_sop_b, raw_eop_b, frame_done_b, err_line_len_b, err_protocol_b;

  always #5 clk = ~clk;

  rgb2raw_bayer_mosaic #(.DATA_WIDTH(8), .LINE_PIXELS(LP), .FRAME_LINES(FL), .BAYER_PHASE(0)) u_rggb (
    .clk(clk), .reset_n(reset_n), .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .rgb_valid(rgb_valid), .rgb_sop(rgb_sop), .rgb_eop(rgb_eop),
    .raw_data(raw_data_a), .raw_valid(raw_valid_a), .raw_sop(raw_sop_a), .raw_eop(raw_eop_a),
    .frame_done(frame_done_a), .err_line_len(err_line_len_a), .err_protocol(err_protocol_a)
  );

  rgb2raw_bayer_mosaic #(.DATA_WIDTH(8), .LINE_PIXELS(LP), .FRAME_LINES(FL), .BAYER_PHASE(3)) u_bggr (
    .clk(clk), .reset_n(reset_n), .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .rgb_valid(rgb_valid), .rgb_sop(rgb_sop), .rgb_eop(rgb_eop),
    .raw_data(raw_data_b), .raw_valid(raw_valid_b), .raw_sop(raw_sop_b), .raw_eop(raw_eop_b),
    .frame_done(frame_done_b), .err_line_len(err_line_len_b), .err_protocol(err_protocol_b)
  );

  typedef struct {
    logic       v, s, e, fd, el, ep;
    logic [7:0] d0, d3;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference state: position in the frame, expressed as plain integers.
  bit         in_line;
  int         col, line;
  logic [7:0] last0, last3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pick(input int ph, input int ln, input int c,
                                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int p, q;
    p = (ln % 2) ^ ((ph >> 1) & 1);
    q = (c % 2) ^ (ph & 1);
    if (p != q) return g;
    return (p == 1) ? b : r;
  endfunction

  function automatic exp_t idle_exp(input logic [7:0] d0, input logic [7:0] d3);
    exp_t x;
    x = '{v: 1'b0, s: 1'b0, e: 1'b0, fd: 1'b0, el: 1'b0, ep: 1'b0, d0: d0, d3: d3};
    return x;
  endfunction

  task automatic check_outputs(input exp_t x);
    check("valid_rggb", raw_valid_a, x.v);
    check("sop_rggb", raw_sop_a, x.s);
    check("eop_rggb", raw_eop_a, x.e);
    check("frame_done_rggb", frame_done_a, x.fd);
    check("err_line_len_rggb", err_line_len_a, x.el);
    check("err_protocol_rggb", err_protocol_a, x.ep);
    check("data_rggb", raw_data_a, x.d0);
    check("valid_bggr", raw_valid_b, x.v);
    check("sop_bggr", raw_sop_b, x.s);
    check("eop_bggr", raw_eop_b, x.e);
    check("frame_done_bggr", frame_done_b, x.fd);
    check("err_line_len_bggr", err_line_len_b, x.el);
    check("err_protocol_bggr", err_protocol_b, x.ep);
    check("data_bggr", raw_data_b, x.d3);
  endtask

  // One clock of stimulus; outputs are checked 1 ns after the edge against
  // the expectation of the pixel presented one step earlier (two-cycle latency).
  task automatic step(input bit v, input bit s, input bit e,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_t x;
    int   mcol;
    x = idle_exp(8'd0, 8'd0);
    rgb_valid = v; rgb_sop = s; rgb_eop = e;
    r_data = r; g_data = g; b_data = b;
    if (v) begin
      if (!in_line && !s) begin
        x.ep = 1'b1;
      end else begin
        x.v = 1'b1; x.s = s; x.e = e;
        if (s) begin
          if (in_line) begin x.ep = 1'b1; x.el = 1'b1; end
          mcol = 0;
        end else begin
          mcol = col;
        end
        last0 = pick(0, line, mcol, r, g, b);
        last3 = pick(3, line, mcol, r, g, b);
        col = (mcol + 1 > SAT) ? SAT : mcol + 1;
        if (e) begin
          if (mcol + 1 != LP) x.el = 1'b1;
          if (line == FL - 1) x.fd = 1'b1;
          line    = (line + 1) % FL;
          in_line = 1'b0;
        end else begin
          in_line = 1'b1;
        end
      end
    end
    x.d0 = last0;
    x.d3 = last3;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    check_outputs(exp_q.pop_front());
  endtask

  task automatic gap();
    step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // gap_mode: 0 back-to-back, 1 alternating valid, 2 random gaps.
  task automatic send_line(input int n, input bit fixed_data, input int gap_mode);
    logic [7:0] r, g, b;
    for (int i = 0; i < n; i++) begin
      if (fixed_data) begin
        r = 8'(10 + i); g = 8'(20 + i); b = 8'(30 + i);
      end else begin
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      end
      step(1'b1, i == 0, i == n - 1, r, g, b);
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) gap();
    end
  endtask

  task automatic do_reset();
    rgb_valid = 1'b0; rgb_sop = 1'b0; rgb_eop = 1'b0;
    reset_n = 1'b0;
    #1;
    check_outputs(idle_exp(8'd0, 8'd0));
    @(posedge clk); #1;
    check_outputs(idle_exp(8'd0, 8'd0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    in_line = 1'b0; col = 0; line = 0; last0 = '0; last3 = '0;
    exp_q.delete();
    exp_q.push_back(idle_exp(8'd0, 8'd0));
  endtask

  initial begin
    #2;
    do_reset();
    gap(); gap();

    // Two fixed 4-pixel lines: RGGB 10,21,12,23 / 20,31,22,33; BGGR 30,21,32,23 / 20,11,22,13.
    send_line(4, 1'b1, 0);
    send_line(4, 1'b1, 0);
    // Third line closes the frame; fourth wraps to the line-0 pattern.
    send_line(4, 1'b0, 0);
    send_line(4, 1'b1, 0);
    gap();

    // Short line, then a stray valid pixel outside any line.
    send_line(3, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 8'd3);
    gap();

    // sop in the middle of a line restarts it.
    step(1'b1, 1'b1, 1'b0, 8'd40, 8'd50, 8'd60);
    step(1'b1, 1'b0, 1'b0, 8'd41, 8'd51, 8'd61);
    send_line(4, 1'b0, 0);

    // One-pixel line (sop and eop together), then a column-saturating long line.
    send_line(1, 1'b0, 0);
    send_line(10, 1'b0, 0);

    // Alternating valid over one line.
    send_line(4, 1'b1, 1);

    // Random line lengths, random gaps, occasional stray pixels.
    for (int k = 0; k < 30; k++) begin
      send_line($urandom_range(1, 6), 1'b0, 2);
      if ($urandom_range(0, 4) == 0) step(1'b1, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    // Reset after pixel 2 of a line; the next line must start clean at line 0.
    step(1'b1, 1'b1, 1'b0, 8'd70, 8'd80, 8'd90);
    step(1'b1, 1'b0, 1'b0, 8'd71, 8'd81, 8'd91);
    do_reset();
    gap();
    send_line(4, 1'b1, 0);
    gap(); gap(); gap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
